// File: rtl/bram_vec_dma.sv
// bram_vec_dma: vector load/store engine in front of a BRAM port with fixed read latency.
// Optional range check enabled by defining BRAM_DMA_BOUNDS_EN.
module bram_vec_dma #(
    parameter int unsigned LANES     = 4,
    parameter int unsigned ADDR_W    = 13,
    parameter int unsigned DATA_W    = 32,
    parameter int unsigned RD_LAT    = 2,
    parameter int unsigned MEM_WORDS = 50
) (
    input  logic                    CLK,
    input  logic                    RST,
    input  logic                    cmd_valid,
    output logic                    cmd_ready,
    input  logic                    cmd_write,
    input  logic [ADDR_W-1:0]       cmd_addr,
    input  logic [7:0]              cmd_len,
    output logic [LANES*DATA_W-1:0] vec_out,
    output logic                    vec_out_valid,
    input  logic                    vec_out_ready,
    input  logic [LANES*DATA_W-1:0] vec_in,
    input  logic                    vec_in_valid,
    output logic                    vec_in_ready,
    output logic [ADDR_W-1:0]       addrb,
    output logic [DATA_W-1:0]       dinb,
    input  logic [DATA_W-1:0]       doutb,
    output logic                    enb,
    output logic [3:0]              web,
    output logic                    busy,
    output logic                    done,
    output logic                    err
);
    localparam int unsigned       CNT_W      = $clog2(LANES + RD_LAT + 1);
    localparam logic [CNT_W-1:0]  ISSUE_LAST = CNT_W'(LANES - 1);
    localparam logic [CNT_W-1:0]  CNT_LAST   = CNT_W'(LANES + RD_LAT - 1);
    localparam logic [ADDR_W-1:0] STEP       = ADDR_W'(LANES);

    typedef enum logic [2:0] {
        S_IDLE, S_RD_ISSUE, S_RD_DRAIN, S_RD_OUT, S_WR_WAIT, S_WR_ISSUE, S_FIN
    } state_t;

    state_t                  state_q;
    logic [ADDR_W-1:0]       ptr_q;
    logic [7:0]              left_q;
    logic [CNT_W-1:0]        cnt_q;
    logic [LANES*DATA_W-1:0] wbuf_q;
    logic [LANES*DATA_W-1:0] vec_out_q;
    logic                    cmd_ready_q, vec_out_valid_q, vec_in_ready_q;
    logic [ADDR_W-1:0]       addrb_q;
    logic [DATA_W-1:0]       dinb_q;
    logic                    enb_q, busy_q, done_q;
    logic [3:0]              web_q;
    logic                    oob;

`ifdef BRAM_DMA_BOUNDS_EN
    localparam int unsigned EXT_W = ADDR_W + 40;
    logic [EXT_W-1:0] rng_last;
    logic             err_q;

    // Range end is computed wide so a command running past 2^ADDR_W is caught, not wrapped.
    always_comb begin
        rng_last = EXT_W'(cmd_addr) + EXT_W'(cmd_len) * EXT_W'(LANES) - EXT_W'(1);
        oob      = (cmd_len != '0) && ((cmd_addr == '0) || (rng_last >= EXT_W'(MEM_WORDS)));
    end

    always_ff @(posedge CLK) begin
        err_q <= !RST && (state_q == S_IDLE) && cmd_valid && cmd_ready_q && oob;
    end

    assign err = err_q;
`else
    assign oob = 1'b0;
    assign err = 1'b0;
`endif

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q         <= S_IDLE;
            ptr_q           <= '0;
            left_q          <= '0;
            cnt_q           <= '0;
            wbuf_q          <= '0;
            vec_out_q       <= '0;
            cmd_ready_q     <= 1'b1;
            vec_out_valid_q <= 1'b0;
            vec_in_ready_q  <= 1'b0;
            addrb_q         <= '0;
            dinb_q          <= '0;
            enb_q           <= 1'b0;
            web_q           <= '0;
            busy_q          <= 1'b0;
            done_q          <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (cmd_valid && cmd_ready_q) begin
                        cmd_ready_q <= 1'b0;
                        ptr_q       <= cmd_addr;
                        left_q      <= cmd_len;
                        cnt_q       <= '0;
                        if ((cmd_len == '0) || oob) begin
                            state_q <= S_FIN;
                            done_q  <= 1'b1;
                        end else if (cmd_write) begin
                            state_q        <= S_WR_WAIT;
                            vec_in_ready_q <= 1'b1;
                            busy_q         <= 1'b1;
                        end else begin
                            state_q <= S_RD_ISSUE;
                            addrb_q <= cmd_addr;
                            enb_q   <= 1'b1;
                            busy_q  <= 1'b1;
                        end
                    end
                end
                // cnt_q counts cycles since the first issue; lane i lands RD_LAT cycles after its issue.
                S_RD_ISSUE, S_RD_DRAIN: begin
                    cnt_q <= cnt_q + CNT_W'(1);
                    for (int unsigned i = 0; i < LANES; i++) begin
                        if (cnt_q == CNT_W'(i + RD_LAT))
                            vec_out_q[i*DATA_W +: DATA_W] <= doutb;
                    end
                    if (cnt_q < ISSUE_LAST)
                        addrb_q <= addrb_q + ADDR_W'(1);
                    if (cnt_q == CNT_LAST) begin
                        state_q         <= S_RD_OUT;
                        enb_q           <= 1'b0;
                        vec_out_valid_q <= 1'b1;
                    end else if (cnt_q >= ISSUE_LAST) begin
                        state_q <= S_RD_DRAIN;
                    end
                end
                S_RD_OUT: begin
                    if (vec_out_ready) begin
                        vec_out_valid_q <= 1'b0;
                        if (left_q > 8'd1) begin
                            left_q  <= left_q - 8'd1;
                            ptr_q   <= ptr_q + STEP;
                            addrb_q <= ptr_q + STEP;
                            enb_q   <= 1'b1;
                            cnt_q   <= '0;
                            state_q <= S_RD_ISSUE;
                        end else begin
                            state_q <= S_FIN;
                            done_q  <= 1'b1;
                            busy_q  <= 1'b0;
                        end
                    end
                end
                S_WR_WAIT: begin
                    if (vec_in_valid) begin
                        vec_in_ready_q <= 1'b0;
                        addrb_q        <= ptr_q;
                        dinb_q         <= vec_in[DATA_W-1:0];
                        wbuf_q         <= vec_in >> DATA_W;
                        web_q          <= 4'hF;
                        cnt_q          <= '0;
                        state_q        <= S_WR_ISSUE;
                    end
                end
                S_WR_ISSUE: begin
                    if (cnt_q == ISSUE_LAST) begin
                        web_q <= '0;
                        if (left_q > 8'd1) begin
                            left_q         <= left_q - 8'd1;
                            ptr_q          <= ptr_q + STEP;
                            vec_in_ready_q <= 1'b1;
                            state_q        <= S_WR_WAIT;
                        end else begin
                            state_q <= S_FIN;
                            done_q  <= 1'b1;
                            busy_q  <= 1'b0;
                        end
                    end else begin
                        cnt_q   <= cnt_q + CNT_W'(1);
                        addrb_q <= addrb_q + ADDR_W'(1);
                        dinb_q  <= wbuf_q[DATA_W-1:0];
                        wbuf_q  <= wbuf_q >> DATA_W;
                    end
                end
                S_FIN: begin
                    state_q     <= S_IDLE;
                    cmd_ready_q <= 1'b1;
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign cmd_ready     = cmd_ready_q;
    assign vec_out       = vec_out_q;
    assign vec_out_valid = vec_out_valid_q;
    assign vec_in_ready  = vec_in_ready_q;
    assign addrb         = addrb_q;
    assign dinb          = dinb_q;
    assign enb           = enb_q;
    assign web           = web_q;
    assign busy          = busy_q;
    assign done          = done_q;
endmodule

// File: tb/tb_bram_vec_dma.sv
// Directed bench for bram_vec_dma with a 2-cycle enb-gated BRAM model.
// Checks the range-rejection path when built with BRAM_DMA_BOUNDS_EN.
module tb_bram_vec_dma;
    localparam int unsigned LANES = 4, ADDR_W = 13, DATA_W = 32, RD_LAT = 2, MEM_WORDS = 50;
    localparam logic [127:0] EXP1 = 128'h00000041_0000002A_00000014_0000000F;
    localparam logic [127:0] EXP2 = 128'h0000001F_0000001C_00000019_00000016;
    localparam logic [127:0] VST  = 128'h00000004_00000003_00000002_00000001;

    logic CLK = 1'b0, RST = 1'b1;
    logic cmd_valid = 1'b0, cmd_write = 1'b0;
    logic [ADDR_W-1:0] cmd_addr = '0;
    logic [7:0] cmd_len = '0;
    logic [LANES*DATA_W-1:0] vec_out, vec_in = '0;
    logic vec_out_valid, vec_out_ready = 1'b0, vec_in_valid = 1'b0, vec_in_ready, cmd_ready;
    logic [ADDR_W-1:0] addrb;
    logic [DATA_W-1:0] dinb, doutb;
    logic enb, busy, done, err;
    logic [3:0] web;

    int n_cmp = 0, n_err = 0;
    int enb_cnt = 0, web_cnt = 0, done_cnt = 0, log_n = 0;
    int addr_log [0:1023];
    logic [31:0] mem [0:8191];
    logic [31:0] rd_s1;

    always #5 CLK = ~CLK;

    bram_vec_dma #(.LANES(LANES), .ADDR_W(ADDR_W), .DATA_W(DATA_W), .RD_LAT(RD_LAT), .MEM_WORDS(MEM_WORDS)) dut (
        .CLK(CLK), .RST(RST), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
        .cmd_addr(cmd_addr), .cmd_len(cmd_len), .vec_out(vec_out), .vec_out_valid(vec_out_valid),
        .vec_out_ready(vec_out_ready), .vec_in(vec_in), .vec_in_valid(vec_in_valid), .vec_in_ready(vec_in_ready),
        .addrb(addrb), .dinb(dinb), .doutb(doutb), .enb(enb), .web(web), .busy(busy), .done(done), .err(err)
    );

    // BRAM: two enb-gated register stages on the read path, byte-enabled writes.
    initial begin
        for (int a = 0; a < 8192; a++) mem[a] = 32'(a * 3 + 7);
        mem[1] = 32'd15; mem[2] = 32'd20; mem[3] = 32'd42; mem[4] = 32'd65;
        mem[8190] = 32'hAAAA0001; mem[8191] = 32'hAAAA0002;
        forever begin
            @(posedge CLK);
            for (int b = 0; b < 4; b++) if (web[b]) mem[addrb][8*b +: 8] <= dinb[8*b +: 8];
            if (enb) begin
                rd_s1 <= mem[addrb];
                doutb <= rd_s1;
            end
        end
    end

    always @(negedge CLK) begin
        if (enb) begin
            enb_cnt++;
            if (log_n < 1024) begin
                addr_log[log_n] = int'(addrb);
                log_n++;
            end
        end
        if (web != 4'h0) web_cnt++;
        if (done) done_cnt++;
    end

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic send_cmd(input logic wr, input logic [ADDR_W-1:0] a, input logic [7:0] l);
        cmd_valid = 1'b1; cmd_write = wr; cmd_addr = a; cmd_len = l;
        tick();
        cmd_valid = 1'b0;
    endtask

    task automatic wait_vout(output int n);
        n = 0;
        while (!vec_out_valid && n < 40) begin
            tick();
            n++;
        end
    endtask

    task automatic wait_done(output int n);
        n = 0;
        while (!done && n < 40) begin
            tick();
            n++;
        end
    endtask

    task automatic take_vec();
        vec_out_ready = 1'b1;
        tick();
        vec_out_ready = 1'b0;
    endtask

    initial begin
        int n, e0, w0, d0, l0;
        logic stable;

        repeat (3) tick();
        RST = 1'b0;
        chk("rst_cmd_ready", 128'(cmd_ready), 128'(1));
        chk("rst_ctrl", 128'({busy, done, err, enb, web, vec_out_valid, vec_in_ready}), 128'(0));
        chk("rst_addrb", 128'(addrb), 128'(0));
        chk("rst_vec_out", 128'(vec_out), 128'(0));

        // single-vector load
        e0 = enb_cnt; d0 = done_cnt;
        send_cmd(1'b0, 13'd1, 8'd1);
        chk("t1_busy", 128'({busy, cmd_ready}), 128'(2'b10));
        wait_vout(n);
        chk("t1_latency", 128'(n), 128'(6));
        chk("t1_vec", 128'(vec_out), EXP1);
        take_vec();
        chk("t1_fin", 128'({done, busy, cmd_ready}), 128'(3'b100));
        tick();
        chk("t1_idle_ready", 128'({cmd_ready, done}), 128'(2'b10));
        tick();
        chk("t1_done_cnt", 128'(done_cnt - d0), 128'(1));
        chk("t1_enb_cycles", 128'(enb_cnt - e0), 128'(6));

        // two vectors with back-pressure
        send_cmd(1'b0, 13'd1, 8'd2);
        wait_vout(n);
        chk("t2_vec1", 128'(vec_out), EXP1);
        stable = 1'b1;
        repeat (10) begin
            tick();
            if (vec_out !== EXP1 || vec_out_valid !== 1'b1) stable = 1'b0;
        end
        chk("t2_hold", 128'(stable), 128'(1));
        take_vec();
        wait_vout(n);
        chk("t2_latency2", 128'(n), 128'(6));
        chk("t2_vec2", 128'(vec_out), EXP2);
        take_vec();
        tick();
        tick();

        // single-vector store and readback
        w0 = web_cnt;
        send_cmd(1'b1, 13'd33, 8'd1);
        chk("t3_vin_ready", 128'(vec_in_ready), 128'(1));
        vec_in = VST; vec_in_valid = 1'b1;
        tick();
        vec_in_valid = 1'b0;
        chk("t3_first_write", 128'({web, addrb, dinb}), 128'({4'hF, 13'd33, 32'd1}));
        wait_done(n);
        chk("t3_done_latency", 128'(n), 128'(4));
        tick();
        chk("t3_web_cycles", 128'(web_cnt - w0), 128'(4));
        tick();
        send_cmd(1'b0, 13'd33, 8'd1);
        wait_vout(n);
        chk("t3_readback", 128'(vec_out), VST);
        take_vec();
        tick();
        tick();

        // load across the top of the address space
        e0 = enb_cnt; l0 = log_n;
        send_cmd(1'b0, 13'd8190, 8'd1);
`ifdef BRAM_DMA_BOUNDS_EN
        chk("t4_reject", 128'({err, done}), 128'(2'b11));
        tick();
        tick();
        chk("t4_no_enb", 128'(enb_cnt - e0), 128'(0));
        chk("t4_ready", 128'(cmd_ready), 128'(1));
`else
        wait_vout(n);
        chk("t4_addr_seq", 128'({addr_log[l0], addr_log[l0+1], addr_log[l0+2], addr_log[l0+3]}),
            128'({32'd8190, 32'd8191, 32'd0, 32'd1}));
        chk("t4_vec", 128'(vec_out), 128'h0000000F_00000007_AAAA0002_AAAA0001);
        chk("t4_err", 128'(err), 128'(0));
        take_vec();
        tick();
        tick();
`endif

        // reset while draining reads
        send_cmd(1'b0, 13'd5, 8'd1);
        repeat (4) tick();
        chk("t5_draining", 128'({enb, vec_out_valid}), 128'(2'b10));
        RST = 1'b1;
        tick();
        RST = 1'b0;
        chk("t5_after_rst", 128'({enb, vec_out_valid, cmd_ready}), 128'(3'b001));
        send_cmd(1'b0, 13'd1, 8'd1);
        wait_vout(n);
        chk("t5_reload", 128'(vec_out), EXP1);
        take_vec();
        tick();
        tick();

        // zero-length command
        e0 = enb_cnt; w0 = web_cnt; d0 = done_cnt;
        send_cmd(1'b0, 13'd1, 8'd0);
        chk("t6_len0_done", 128'({done, busy}), 128'(2'b10));
        tick();
        chk("t6_len0_ready", 128'(cmd_ready), 128'(1));
        tick();
        chk("t6_len0_quiet", 128'({enb_cnt - e0, web_cnt - w0, done_cnt - d0}), 128'({32'd0, 32'd0, 32'd1}));

        // commands and store data while busy are ignored
        w0 = web_cnt; d0 = done_cnt;
        send_cmd(1'b0, 13'd1, 8'd1);
        cmd_valid = 1'b1; cmd_write = 1'b1; cmd_addr = 13'd40; cmd_len = 8'd3; vec_in_valid = 1'b1;
        stable = 1'b1;
        repeat (3) begin
            if (cmd_ready !== 1'b0 || vec_in_ready !== 1'b0) stable = 1'b0;
            tick();
        end
        cmd_valid = 1'b0; vec_in_valid = 1'b0;
        chk("t6_busy_closed", 128'(stable), 128'(1));
        wait_vout(n);
        chk("t6_vec", 128'(vec_out), EXP1);
        take_vec();
        tick();
        tick();
        chk("t6_ignored", 128'({web_cnt - w0, done_cnt - d0, {31'd0, cmd_ready}}), 128'({32'd0, 32'd1, 32'd1}));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
